// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, mux-select and FSM encodings for the 3-stage core
//
// Purpose : opcode constants (inst[6:2]), PC-select and forwarding-select
//           encodings, the sequencer state enum, and source-register usage
//           decoders shared by the sequencer and the decoder.
// Ports   : none (package).
package core_pkg;

  // Major opcodes, inst[6:2] (inst[1:0] is always 2'b11 for 32-bit encodings)
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // PC mux select
  localparam logic [1:0] PC_SEL_PC4   = 2'd0;
  localparam logic [1:0] PC_SEL_ALU   = 2'd1;
  localparam logic [1:0] PC_SEL_RESET = 2'd2;
  localparam logic [1:0] PC_SEL_HOLD  = 2'd3;

  // ALU operand source select
  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_WB_ALU  = 2'd1;
  localparam logic [1:0] FWD_WB_LOAD = 2'd2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // rs1 is read by JALR, BRANCH, LOAD, STORE, OP-IMM, OP and the
  // register form of CSRRW (funct3 = 001).
  function automatic logic uses_rs1(input logic [4:0] op, input logic [2:0] funct3);
    logic used;
    used = 1'b0;
    case (op)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: used = 1'b1;
      OPC_SYSTEM: used = (funct3 == 3'b001);
      default: used = 1'b0;
    endcase
    return used;
  endfunction

  // rs2 is read by BRANCH, STORE (store data) and OP.
  function automatic logic uses_rs2(input logic [4:0] op);
    logic used;
    used = 1'b0;
    case (op)
      OPC_BRANCH, OPC_STORE, OPC_OP: used = 1'b1;
      default: used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - cycle and retired-instruction performance counters
//
// Purpose : free-running cycle counter and retire counter, both wrapping
//           modulo 2^CNT_W; a clear strobe beats a same-cycle increment.
// Ports   : clk          in   core clock
//           rst_n        in   synchronous active-low reset
//           cnt_clr      in   clear both counters on the next edge
//           retire       in   one instruction retires this cycle
//           cycle_cnt    out  cycles since reset/clear
//           instret_cnt  out  retired instructions since reset/clear
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_clr,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      // Plain binary add; overflow drops the carry, giving the wrap.
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - boot/flush/stall sequencer and WB->X forwarding for the 3-stage core
//
// Purpose : owns the boot sequence, PC-select mux, wrong-path flush after
//           jumps/taken branches, global freeze on memory stall, WB->X
//           operand forwarding selects and the performance counters.
// Ports   : clk, rst_n                      clock, synchronous active-low reset
//           x_inst, x_valid, x_br_taken     instruction in X and its branch result
//           wb_rd, wb_regwen, wb_is_load,
//           wb_valid                        WB-stage writeback description
//           mem_stall                       freeze the pipeline this cycle
//           cnt_clr                         clear both perf counters
//           pc_sel                          0 PC+4, 1 ALU target, 2 reset vector, 3 hold
//           stage_en                        enable for PC and pipeline registers
//           x_kill                          bubble the instruction entering X
//           fwd_a, fwd_b                    ALU operand sources for rs1 / rs2
//           cycle_cnt, instret_cnt          performance counters
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      x_inst,
  input  logic             x_valid,
  input  logic             x_br_taken,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwen,
  input  logic             wb_is_load,
  input  logic             wb_valid,
  input  logic             mem_stall,
  input  logic             cnt_clr,
  output logic [1:0]       pc_sel,
  output logic             stage_en,
  output logic             x_kill,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t state;
  state_t state_next;

  logic [4:0] op;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       redirect;
  logic       wb_writes;
  logic       hit_a;
  logic       hit_b;
  logic       unused_inst_bits;

  assign op     = x_inst[6:2];
  assign funct3 = x_inst[14:12];
  assign rs1    = x_inst[19:15];
  assign rs2    = x_inst[24:20];

  // Remaining instruction fields carry nothing the sequencer needs.
  assign unused_inst_bits = ^{x_inst[31:25], x_inst[11:7], x_inst[1:0]};

  assign redirect = x_valid &
                    ((op == OPC_JAL) | (op == OPC_JALR) | ((op == OPC_BRANCH) & x_br_taken));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_sel     = PC_SEL_PC4;
    stage_en   = 1'b1;
    x_kill     = 1'b0;
    if (!rst_n) begin
      state_next = BOOT;
      pc_sel     = PC_SEL_RESET;
      x_kill     = 1'b1;
    end else if (mem_stall) begin
      // Whole pipe frozen: inputs do not move, so any redirect in X is
      // simply re-evaluated once the stall drops.
      stage_en = 1'b0;
      pc_sel   = PC_SEL_HOLD;
    end else begin
      case (state)
        BOOT: begin
          pc_sel     = PC_SEL_RESET;
          x_kill     = 1'b1;
          state_next = RUN;
        end
        RUN: begin
          if (redirect) begin
            pc_sel     = PC_SEL_ALU;
            state_next = FLUSH;
          end
        end
        FLUSH: begin
          // Old PC+4 was already fetched; squash it. Redirects are ignored
          // here because X will hold that bubble next.
          x_kill     = 1'b1;
          state_next = RUN;
        end
        default: begin
          pc_sel     = PC_SEL_RESET;
          x_kill     = 1'b1;
          state_next = BOOT;
        end
      endcase
    end
  end

  // x0 is hardwired to zero, so a WB write to it never forwards.
  assign wb_writes = wb_valid & wb_regwen & (wb_rd != 5'd0);
  assign hit_a     = wb_writes & (wb_rd == rs1) & uses_rs1(op, funct3);
  assign hit_b     = wb_writes & (wb_rd == rs2) & uses_rs2(op);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rst_n) begin
      if (hit_a) begin
        fwd_a = wb_is_load ? FWD_WB_LOAD : FWD_WB_ALU;
      end
      if (hit_b) begin
        fwd_b = wb_is_load ? FWD_WB_LOAD : FWD_WB_ALU;
      end
    end
  end

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_clr    (cnt_clr),
    .retire     (wb_valid & stage_en),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

endmodule
